program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning the number of 32-bit instruction words the target program memory holds.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000, meaning the byte address of the first written word.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port ByteIn  input  8  incoming stream byte.
REQ-007 SHALL have port ByteValid  input  1  ByteIn holds a valid byte.
REQ-008 SHALL have port ByteReady  output  1  loader accepts ByteIn this cycle.
REQ-009 SHALL have port MemWrite  output  1  one-cycle program-memory write strobe.
REQ-010 SHALL have port MemAddress  output  32  byte address of the word being written.
REQ-011 SHALL have port MemWriteData  output  32  instruction word being written.
REQ-012 SHALL have port CPUReset  output  1  holds the processor in reset while high.
REQ-013 SHALL have ports Done and Error  output  1 each  load-status flags.

Function
REQ-014 SHALL transfer a byte only when ByteValid and ByteReady are both high on a rising clk edge.
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, CHECK, DONE and ERROR.
REQ-016 In IDLE, DONE and ERROR, SHALL go to LEN on Start, clearing Done, Error, the word counter and the byte counter, and asserting CPUReset.
REQ-017 SHALL ignore Start in LEN, DATA, WRITE and CHECK.
REQ-018 In LEN, SHALL accept one byte N as the word count; N = 0 or N > MEMORY_DEPTH -> ERROR, otherwise -> DATA.
REQ-019 In DATA, SHALL assemble 4 bytes big-endian: 1st byte -> [31:24], 4th byte -> [7:0]; after the 4th byte -> WRITE.
REQ-020 In WRITE, SHALL assert MemWrite for exactly one cycle with MemAddress = BASE_ADDRESS + 4*k (k = word index from 0) and ByteReady low.
REQ-021 SHALL compute MemAddress with 32-bit wrap-around, with no overflow flag.
REQ-022 After WRITE, SHALL go to DATA if k+1 < N, otherwise to CHECK (checksum feature enabled) or DONE.
REQ-023 SHALL drive ByteReady high only in LEN, DATA and CHECK.
REQ-024 In DONE, SHALL hold Done=1 and CPUReset=0 until the next Start or reset.
REQ-025 In ERROR, SHALL hold Error=1 and CPUReset=1; memory contents are undefined.
REQ-026 SHALL produce MemWrite for word k exactly 1 cycle after its 4th byte is accepted; a back-to-back stream SHALL sustain 1 word per 5 cycles.
REQ-027 SHALL keep MemAddress and MemWriteData stable when MemWrite is low.

Reset
REQ-028 On reset SHALL enter IDLE, with ByteReady=0, MemWrite=0, MemAddress=0, MemWriteData=0, CPUReset=1, Done=0, Error=0 and counters 0.
REQ-029 SHALL let reset in any state, including mid-word or during WRITE, abort with no further MemWrite; reset SHALL take priority over Start.

Configuration
REQ-030 SHALL include the checksum feature only when macro PROGRAM_LOADER_CHECKSUM_EN is defined.
REQ-031 With PROGRAM_LOADER_CHECKSUM_EN, SHALL keep an 8-bit sum mod 256 of all data bytes (not N); CHECK accepts one byte, equal -> DONE, unequal -> ERROR.
REQ-032 Without PROGRAM_LOADER_CHECKSUM_EN, SHALL omit the CHECK state and the sum register; the last WRITE -> DONE.

Structure
REQ-033 SHALL place the state encoding and the header and byte-count widths in shared package mips_loader_pkg.
REQ-034 SHALL use one sub-module, word_assembler: an 8-to-32 shift register with byte counter and word_complete pulse.

Verification
REQ-035 Stimulus: Start, N=2, bytes 20 08 00 05 / 01 09 50 20 -> MemWrite at 0x0 data 0x20080005, at 0x4 data 0x01095020; then Done=1, CPUReset=0.
REQ-036 Stimulus: N=0, then separately N=33 with MEMORY_DEPTH=32 -> ERROR, Error=1, CPUReset=1, no MemWrite.
REQ-037 Stimulus: ByteValid toggled randomly, N=3 -> the same three words and addresses as a continuous stream; ByteReady=0 in every WRITE cycle.
REQ-038 Stimulus: reset after the 2nd byte of word 1 -> IDLE with all outputs at reset values; a following Start with a full load -> correct words.
REQ-039 With CHECKSUM_EN, stimulus: N=1, bytes 01 02 03 04, checksum 0x0A -> DONE; checksum 0x0B -> ERROR.
REQ-040 Stimulus: Start during DATA -> ignored; Start in DONE -> new load, Done cleared and CPUReset=1 on the next cycle.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: state encoding, field widths and address helper shared by program_loader.
// ST_CHECK exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

   localparam int HDR_W      = 8;
   localparam int BYTE_CNT_W = 2;
   localparam int WORD_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK = 3'd4,
`endif
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } state_t;

   // Byte address of word 'index'; plain 32-bit add, so it wraps silently.
   function automatic logic [WORD_W-1:0] word_address(input logic [WORD_W-1:0] base,
                                                      input logic [HDR_W-1:0]  index);
      return base + {{(WORD_W-HDR_W-2){1'b0}}, index, 2'b00};
   endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: collects four stream bytes big-endian into one 32-bit word.
// o_word/o_word_complete already include the byte being shifted in this cycle.
module word_assembler
   import mips_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_shift,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_complete
);

   logic [23:0]           r_shift;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;

   // Shift register and byte position within the current word
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_shift    <= 24'd0;
         r_byte_cnt <= 2'd0;
      end else if (i_shift) begin
         r_shift    <= {r_shift[15:0], i_byte};
         r_byte_cnt <= r_byte_cnt + 2'd1;
      end
   end

   assign o_word          = {r_shift, i_byte};
   assign o_word_complete = i_shift & (r_byte_cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// program_loader: takes a length-prefixed byte stream and writes it word by word into program memory.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module program_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned MEMORY_DEPTH = 32,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        MemWrite,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        CPUReset,
   output logic        Done,
   output logic        Error
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [HDR_W-1:0]  r_word_total;
   logic [HDR_W-1:0]  r_word_cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   logic              w_accept;
   logic              w_shift;
   logic              w_restart;
   logic              w_len_bad;
   logic              w_more_words;
   logic              w_word_complete;
   logic [WORD_W-1:0] w_word;

   logic              w_byte_ready_nxt;
   logic              w_mem_write_nxt;
   logic              w_cpu_reset_nxt;
   logic              w_done_nxt;
   logic              w_error_nxt;
   logic [31:0]       w_addr_nxt;
   logic [31:0]       w_data_nxt;

   assign w_accept     = ByteValid & ByteReady;
   assign w_shift      = w_accept & (r_state == ST_DATA);
   assign w_restart    = Start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERROR));
   assign w_len_bad    = (ByteIn == 8'd0) | ({24'd0, ByteIn} > MEMORY_DEPTH);
   assign w_more_words = ({1'b0, r_word_cnt} + 9'd1) < {1'b0, r_word_total};

   word_assembler u_word_assembler (
      .clk             (clk),
      .reset           (reset),
      .i_clear         (w_restart),
      .i_shift         (w_shift),
      .i_byte          (ByteIn),
      .o_word          (w_word),
      .o_word_complete (w_word_complete)
   );

   // State register; outputs are registered from the decoded next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         ByteReady    <= 1'b0;
         MemWrite     <= 1'b0;
         MemAddress   <= 32'd0;
         MemWriteData <= 32'd0;
         CPUReset     <= 1'b1;
         Done         <= 1'b0;
         Error        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         ByteReady    <= w_byte_ready_nxt;
         MemWrite     <= w_mem_write_nxt;
         MemAddress   <= w_addr_nxt;
         MemWriteData <= w_data_nxt;
         CPUReset     <= w_cpu_reset_nxt;
         Done         <= w_done_nxt;
         Error        <= w_error_nxt;
      end
   end

   // Next-state logic; Start is only honoured while no load is in flight
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (Start) w_state_nxt = ST_LEN;
            else       w_state_nxt = r_state;
         end
         ST_LEN: begin
            if (w_accept) begin
               if (w_len_bad) w_state_nxt = ST_ERROR;
               else           w_state_nxt = ST_DATA;
            end else begin
               w_state_nxt = ST_LEN;
            end
         end
         ST_DATA: begin
            if (w_word_complete) w_state_nxt = ST_WRITE;
            else                 w_state_nxt = ST_DATA;
         end
         ST_WRITE: begin
            if (w_more_words) w_state_nxt = ST_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            else              w_state_nxt = ST_CHECK;
`else
            else              w_state_nxt = ST_DONE;
`endif
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (w_accept) begin
               if (ByteIn == r_sum) w_state_nxt = ST_DONE;
               else                 w_state_nxt = ST_ERROR;
            end else begin
               w_state_nxt = ST_CHECK;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode; address/data only move when a write is launched
   always_comb begin
      w_byte_ready_nxt = 1'b0;
      w_mem_write_nxt  = 1'b0;
      w_cpu_reset_nxt  = 1'b1;
      w_done_nxt       = 1'b0;
      w_error_nxt      = 1'b0;
      w_addr_nxt       = MemAddress;
      w_data_nxt       = MemWriteData;
      case (w_state_nxt)
         ST_LEN, ST_DATA: w_byte_ready_nxt = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CHECK:        w_byte_ready_nxt = 1'b1;
`endif
         ST_WRITE: begin
            w_mem_write_nxt = 1'b1;
            w_addr_nxt      = word_address(BASE_ADDRESS, r_word_cnt);
            w_data_nxt      = w_word;
         end
         ST_DONE: begin
            w_done_nxt      = 1'b1;
            w_cpu_reset_nxt = 1'b0;
         end
         ST_ERROR:        w_error_nxt = 1'b1;
         default:         w_byte_ready_nxt = 1'b0;
      endcase
   end

   // Word count, word index and running checksum
   always_ff @(posedge clk) begin
      if (reset) begin
         r_word_total <= 8'd0;
         r_word_cnt   <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_sum        <= 8'd0;
`endif
      end else if (w_restart) begin
         r_word_total <= 8'd0;
         r_word_cnt   <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_sum        <= 8'd0;
`endif
      end else begin
         if ((r_state == ST_LEN) && w_accept) r_word_total <= ByteIn;
         if (r_state == ST_WRITE)             r_word_cnt   <= r_word_cnt + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         if (w_shift)                         r_sum        <= r_sum + ByteIn;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven loads plus hand-written corner sequences; writes checked via scoreboard.
// Honours PROGRAM_LOADER_CHECKSUM_EN the same way as the design.
module tb_program_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, Start, ByteValid;
   logic [7:0]  ByteIn;
   logic        ByteReady, MemWrite, CPUReset, Done, Error;
   logic [31:0] MemAddress, MemWriteData;

   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int n; bit gaps; bit exp_err; } vec_t;

   wr_t         sb[$];
   logic [31:0] words[$];
   vec_t        vecs[8];
   int          n_cmp = 0, n_mis = 0;
   int          cyc = 0, wr_count = 0, load_base = 0, last_wr_cyc = 0;
   bit          chk_gap = 1'b0;
   logic [31:0] prev_addr, prev_data;
   logic        prev_rst = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   program_loader #(.MEMORY_DEPTH(32), .BASE_ADDRESS(BASE)) dut (
      .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .MemWrite(MemWrite), .MemAddress(MemAddress),
      .MemWriteData(MemWriteData), .CPUReset(CPUReset), .Done(Done), .Error(Error)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_reset_values();
      check1 ("rst_ready",   ByteReady,    1'b0);
      check1 ("rst_write",   MemWrite,     1'b0);
      check32("rst_addr",    MemAddress,   32'd0);
      check32("rst_data",    MemWriteData, 32'd0);
      check1 ("rst_cpurst",  CPUReset,     1'b1);
      check1 ("rst_done",    Done,         1'b0);
      check1 ("rst_error",   Error,        1'b0);
   endtask

   // Pops the scoreboard on every write, checks write spacing and output stability
   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (MemWrite) begin
            check1("ready_in_write", ByteReady, 1'b0);
            if (sb.size() == 0) begin
               n_cmp++;
               n_mis++;
               $display("FAIL unexpected_write: got write addr 0x%08h data 0x%08h want no write",
                        MemAddress, MemWriteData);
            end else begin
               e = sb.pop_front();
               check32("wr_addr", MemAddress, e.addr);
               check32("wr_data", MemWriteData, e.data);
            end
            if (chk_gap && (wr_count > load_base)) check32("wr_gap", 32'(cyc - last_wr_cyc), 32'd5);
            wr_count++;
            last_wr_cyc = cyc;
         end else if (!prev_rst && !reset) begin
            check32("addr_hold", MemAddress, prev_addr);
            check32("data_hold", MemWriteData, prev_data);
         end
         prev_addr = MemAddress;
         prev_data = MemWriteData;
         prev_rst  = reset;
      end
   endtask

   // Offers one byte and returns on the falling edge after it was taken
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int budget;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            ByteValid = 1'b0;
            @(negedge clk);
         end
      end
      ByteIn    = b;
      ByteValid = 1'b1;
      budget    = 0;
      while (ByteReady !== 1'b1 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check1("byte_ready_wait", ByteReady, 1'b1);
      @(negedge clk);
   endtask

   task automatic start_pulse();
      ByteValid = 1'b0;
      Start     = 1'b1;
      @(negedge clk);
      Start     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum      = 8'd0;
`endif
      check1("start_done_clr",  Done,      1'b0);
      check1("start_err_clr",   Error,     1'b0);
      check1("start_cpurst",    CPUReset,  1'b1);
      check1("start_len_ready", ByteReady, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w, input int k, input bit gaps, input int start_at);
      wr_t e;
      e.addr = BASE + (32'(k) << 2);
      e.data = w;
      sb.push_back(e);
      for (int b = 0; b < 4; b++) begin
         if (b == start_at) begin
            ByteValid = 1'b0;
            Start     = 1'b1;
            @(negedge clk);
            Start     = 1'b0;
            check1("start_in_data_rdy", ByteReady, 1'b1);
            check1("start_in_data_cpu", CPUReset,  1'b1);
         end
         send_byte(w[31-8*b -: 8], gaps);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum = csum + w[31-8*b -: 8];
`endif
      end
      check1("wr_latency", MemWrite, 1'b1);
   endtask

   task automatic finish_ok();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(csum, 1'b0);
      ByteValid = 1'b0;
`else
      ByteValid = 1'b0;
      @(negedge clk);
`endif
      check1("done_flag",   Done,      1'b1);
      check1("done_cpurst", CPUReset,  1'b0);
      check1("done_error",  Error,     1'b0);
      check1("done_ready",  ByteReady, 1'b0);
   endtask

   task automatic run_load(input int n, input bit gaps, input bit exp_err);
      start_pulse();
      chk_gap   = !gaps;
      load_base = wr_count;
      send_byte(8'(n), gaps);
      if (exp_err) begin
         ByteValid = 1'b0;
         check1("err_flag",   Error,     1'b1);
         check1("err_cpurst", CPUReset,  1'b1);
         check1("err_done",   Done,      1'b0);
         check1("err_ready",  ByteReady, 1'b0);
         repeat (4) @(negedge clk);
         check1("err_hold",   Error,     1'b1);
      end else begin
         for (int k = 0; k < n; k++) send_word(words[k], k, gaps, -1);
         finish_ok();
      end
      chk_gap = 1'b0;
   endtask

   initial begin
      vecs[0] = '{n: 0,   gaps: 1'b0, exp_err: 1'b1};
      vecs[1] = '{n: 33,  gaps: 1'b0, exp_err: 1'b1};
      vecs[2] = '{n: 255, gaps: 1'b1, exp_err: 1'b1};
      vecs[3] = '{n: 1,   gaps: 1'b0, exp_err: 1'b0};
      vecs[4] = '{n: 3,   gaps: 1'b0, exp_err: 1'b0};
      vecs[5] = '{n: 3,   gaps: 1'b1, exp_err: 1'b0};
      vecs[6] = '{n: 32,  gaps: 1'b0, exp_err: 1'b0};
      vecs[7] = '{n: 32,  gaps: 1'b1, exp_err: 1'b0};

      reset     = 1'b1;
      Start     = 1'b0;
      ByteValid = 1'b0;
      ByteIn    = 8'h00;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      check_reset_values();
      reset = 1'b0;
      @(negedge clk);
      check1("idle_ready", ByteReady, 1'b0);
      check1("idle_cpurst", CPUReset, 1'b1);

      // Reference two-word program
      words = '{32'h2008_0005, 32'h0109_5020};
      run_load(2, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         words.delete();
         if (!vecs[i].exp_err) begin
            for (int k = 0; k < vecs[i].n; k++) words.push_back($urandom);
         end
         run_load(vecs[i].n, vecs[i].gaps, vecs[i].exp_err);
      end

      // Reset after the 2nd byte of word 1
      start_pulse();
      send_byte(8'd2, 1'b0);
      send_word(32'hCAFE_F00D, 0, 1'b0, -1);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      ByteValid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      check_reset_values();
      repeat (8) @(negedge clk);
      check1("abort_idle_ready", ByteReady, 1'b0);
      words = '{32'h8C08_0000, 32'hAC09_0004};
      run_load(2, 1'b0, 1'b0);

      // Start during DATA is ignored; Start in DONE begins a new load
      start_pulse();
      send_byte(8'd1, 1'b0);
      send_word(32'hA1B2_C3D4, 0, 1'b0, 2);
      finish_ok();
      words = '{32'h0BAD_BEEF};
      run_load(1, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      start_pulse();
      send_byte(8'd1, 1'b0);
      send_word(32'h0102_0304, 0, 1'b0, -1);
      send_byte(8'h0A, 1'b0);
      ByteValid = 1'b0;
      check1("csum_ok_done", Done, 1'b1);
      start_pulse();
      send_byte(8'd1, 1'b0);
      send_word(32'h0102_0304, 0, 1'b0, -1);
      send_byte(8'h0B, 1'b0);
      ByteValid = 1'b0;
      check1("csum_bad_error",  Error,    1'b1);
      check1("csum_bad_cpurst", CPUReset, 1'b1);
`endif

      repeat (3) @(negedge clk);
      check32("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
